// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample path: frame size, sample widths,
// loader state encoding and the {imag, real} RAM word packing helper.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 7;
  localparam int unsigned FFT_SMP_W  = 13;
  localparam int unsigned FFT_RAM_W  = 2 * FFT_SMP_W;

  typedef enum logic [0:0] {
    StFill,
    StWaitFft
  } ld_state_e;

  // Real part occupies the low half so a real-only word is just a zero-extended sample.
  function automatic logic [FFT_RAM_W-1:0] pack_ram_word(input logic [FFT_SMP_W-1:0] im,
                                                        input logic [FFT_SMP_W-1:0] re);
    return {im, re};
  endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// Codec-strobe, FFT-handshake and RAM write-port signals of the sample loader.
// master drives samples / fft_done; slave is the loader itself.
interface fft_sample_loader_if #(
    parameter int unsigned N_LOG2 = 7,
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned SMP_W  = 13
);

  logic [DIN_W-1:0]   sample_in;
  logic               sample_valid;
  logic               fft_done;
  logic               ram_en;
  logic               ram_we;
  logic [N_LOG2-1:0]  ram_addr;
  logic [2*SMP_W-1:0] ram_din;
  logic               fft_start;
  logic               busy;
  logic [7:0]         dropped;

  modport master (
    output sample_in,
    output sample_valid,
    output fft_done,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_din,
    input  fft_start,
    input  busy,
    input  dropped
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  fft_done,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_din,
    output fft_start,
    output busy,
    output dropped
  );

endinterface

// File: rtl/bit_reverse.sv
// Purely combinational bit-order reversal; shared by the FFT loader and unloader
// for address generation.
module bit_reverse #(
    parameter int unsigned Width = 7
) (
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] out_o
);

  for (genvar i = 0; i < Width; i++) begin : g_rev
    assign out_o[i] = in_i[Width-1-i];
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Collects one frame of audio samples into the FFT RAM as {0, truncated sample}, then
// pulses fft_start and drops samples until fft_done. Define FFT_LOADER_BITREV_EN for
// bit-reversed write addresses; otherwise addresses are in natural order.
module fft_sample_loader
  import fft_pkg::*;
#(
    parameter int unsigned N_LOG2 = FFT_N_LOG2,
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned SMP_W  = FFT_SMP_W
) (
    input logic                clk,
    input logic                rst_n,
    fft_sample_loader_if.slave ld_if
);

  ld_state_e          state_q;
  logic [N_LOG2-1:0]  cnt_q;
  logic               ram_we_q;
  logic [N_LOG2-1:0]  ram_addr_q;
  logic [2*SMP_W-1:0] ram_din_q;
  logic               last_q;
  logic               fft_start_q;
  logic               busy_q;
  logic [7:0]         dropped_q;

  logic [N_LOG2-1:0]  rev_addr;
  logic [N_LOG2-1:0]  wr_addr;
  logic [SMP_W-1:0]   smp_trunc;

  bit_reverse #(
    .Width(N_LOG2)
  ) u_bit_reverse (
    .in_i (cnt_q),
    .out_o(rev_addr)
  );

`ifdef FFT_LOADER_BITREV_EN
  assign wr_addr = rev_addr;
`else
  logic unused_rev_addr;
  assign unused_rev_addr = ^rev_addr;
  assign wr_addr         = cnt_q;
`endif

  // Plain truncation: the dropped LSBs are intentionally discarded, no rounding.
  assign smp_trunc = ld_if.sample_in[DIN_W-1 -: SMP_W];

  logic unused_lsbs;
  assign unused_lsbs = ^ld_if.sample_in[DIN_W-SMP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      last_q      <= 1'b0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= '0;
    end else begin
      ram_we_q <= 1'b0;
      last_q   <= 1'b0;
      // fft_start trails the final write by one cycle so the RAM holds it before the FFT reads.
      fft_start_q <= last_q;

      unique case (state_q)
        StFill: begin
          if (ld_if.sample_valid) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= wr_addr;
            ram_din_q  <= {{SMP_W{1'b0}}, smp_trunc};
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_q <= StWaitFft;
              busy_q  <= 1'b1;
              last_q  <= 1'b1;
            end
          end
        end
        StWaitFft: begin
          if (ld_if.sample_valid && (dropped_q != 8'hFF)) begin
            dropped_q <= dropped_q + 8'd1;
          end
          if (ld_if.fft_done) begin
            state_q <= StFill;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign ld_if.ram_en    = ram_we_q;
  assign ld_if.ram_we    = ram_we_q;
  assign ld_if.ram_addr  = ram_addr_q;
  assign ld_if.ram_din   = ram_din_q;
  assign ld_if.fft_start = fft_start_q;
  assign ld_if.busy      = busy_q;
  assign ld_if.dropped   = dropped_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: cycle model plus write scoreboard, a
// truncation vector table and hand-written frame / drop / reset sequences.
module tb_fft_sample_loader;

  localparam int unsigned NL = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 13;
  localparam int          N  = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_sample_loader_if #(.N_LOG2(NL), .DIN_W(DW), .SMP_W(SW)) bus ();

  fft_sample_loader #(
    .N_LOG2(NL),
    .DIN_W (DW),
    .SMP_W (SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ld_if(bus)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [25:0] din;
  } wr_t;

  typedef struct {
    logic [15:0] smp;
    logic [12:0] re;
  } vec_t;

  int checks = 0;
  int errors = 0;

  wr_t  sb[$];
  bit   m_wait;
  int   m_cnt;
  logic [7:0]  m_drop;
  bit   m_busy, m_last, m_start;
  logic [6:0]  m_addr;
  logic [25:0] m_din;
  int   n_writes, n_starts;
  bit   seen[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_addr(input int c);
    logic [6:0] cc;
    logic [6:0] r;
    cc = c[6:0];
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < 7; i++) r[i] = cc[6-i];
`else
    r = cc;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_cnt = 0; m_drop = '0; m_busy = 0; m_last = 0; m_start = 0;
    m_addr = '0; m_din = '0;
    sb.delete();
  endtask

  // One clock: drive inputs, advance model, then compare outputs 1 time unit after the edge.
  task automatic step(input bit v, input logic [15:0] s, input bit done);
    wr_t w;
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.fft_done     = done;
    m_start = m_last;
    m_last  = 0;
    if (!m_wait) begin
      if (v) begin
        w.addr = exp_addr(m_cnt);
        w.din  = {13'h0, s[15:3]};
        sb.push_back(w);
        m_addr = w.addr;
        m_din  = w.din;
        if (m_cnt == N - 1) begin
          m_wait = 1; m_busy = 1; m_last = 1;
        end
        m_cnt = (m_cnt + 1) % N;
      end
    end else begin
      if (v && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (done) begin
        m_wait = 0; m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.fft_done     = 1'b0;
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("fft_start", 32'(bus.fft_start), 32'(m_start));
    check("dropped", 32'(bus.dropped), 32'(m_drop));
    check("ram_en_eq_we", 32'(bus.ram_en), 32'(bus.ram_we));
    if (bus.fft_start === 1'b1) n_starts++;
    if (bus.ram_we === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h, expected no write at %0t",
                 bus.ram_addr, $time);
      end else begin
        w = sb.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(w.addr));
        check("wr_din", 32'(bus.ram_din), 32'(w.din));
        seen[bus.ram_addr] = 1'b1;
      end
    end else if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL missing_write: got ram_we 0, expected write to %0h at %0t",
               sb[0].addr, $time);
      sb.delete();
    end else begin
      check("addr_hold", 32'(bus.ram_addr), 32'(m_addr));
      check("din_hold", 32'(bus.ram_din), 32'(m_din));
    end
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ram_en", 32'(bus.ram_en), 32'h0);
    check("rst_ram_we", 32'(bus.ram_we), 32'h0);
    check("rst_fft_start", 32'(bus.fft_start), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_din", 32'(bus.ram_din), 32'h0);
    check("rst_dropped", 32'(bus.dropped), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0);
  endtask

  function automatic int count_seen();
    int d = 0;
    for (int i = 0; i < N; i++) if (seen[i]) d++;
    return d;
  endfunction

  initial begin
    vec_t tbl[6];
    int   k1_addr;
    tbl[0] = '{smp: 16'h8000, re: 13'h1000};
    tbl[1] = '{smp: 16'h7FFF, re: 13'h0FFF};
    tbl[2] = '{smp: 16'hFFFF, re: 13'h1FFF};
    tbl[3] = '{smp: 16'h0008, re: 13'h0001};
    tbl[4] = '{smp: 16'h0007, re: 13'h0000};
    tbl[5] = '{smp: 16'hFFF0, re: 13'h1FFE};
`ifdef FFT_LOADER_BITREV_EN
    k1_addr = 64;
`else
    k1_addr = 1;
`endif

    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.fft_done     = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Frame 1: sample k = 8*k
    n_writes = 0; n_starts = 0;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      step(1'b1, 16'(k * 8), 1'b0);
      if (k == 1) begin
        check("k1_addr", 32'(bus.ram_addr), 32'(k1_addr));
        check("k1_din", 32'(bus.ram_din), 32'h1);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    check("f1_writes", 32'(n_writes), 32'd128);
    check("f1_distinct", 32'(count_seen()), 32'd128);
    check("f1_starts", 32'(n_starts), 32'd1);
    check("f1_busy", 32'(bus.busy), 32'h1);

    // Simultaneous fft_done and sample_valid: sample dropped, next one lands at address 0
    step(1'b1, 16'h1234, 1'b1);
    check("sim_dropped", 32'(bus.dropped), 32'h1);
    check("sim_busy", 32'(bus.busy), 32'h0);
    step(1'b1, 16'h0040, 1'b0);
    check("next_we", 32'(bus.ram_we), 32'h1);
    check("next_addr", 32'(bus.ram_addr), 32'h0);

    // fft_done while filling has no effect
    step(1'b0, 16'h0, 1'b1);
    check("done_in_fill_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].smp, 1'b0);
      check("trunc_din", 32'(bus.ram_din), {19'h0, tbl[i].re});
    end

    for (int i = 0; i < N && !m_wait; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);

    // Overflow while the FFT owns the frame
    n_writes = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom), 1'b0);
    check("ovf_writes", 32'(n_writes), 32'd0);
    check("ovf_dropped", 32'(bus.dropped), 32'd255);
    check("ovf_busy", 32'(bus.busy), 32'h1);
    step(1'b0, 16'h0, 1'b1);
    check("ovf_done_busy", 32'(bus.busy), 32'h0);
    check("ovf_done_dropped", 32'(bus.dropped), 32'd255);

    // Reset mid-frame, then a full fresh frame
    for (int i = 0; i < 50; i++) step(1'b1, 16'($urandom), 1'b0);
    do_reset();
    n_starts = 0;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      step(1'b1, 16'($urandom), 1'b0);
      if (i == 0) check("post_rst_addr", 32'(bus.ram_addr), 32'h0);
    end
    check("post_rst_early_start", 32'(n_starts), 32'd0);
    step(1'b1, 16'h7FF8, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("post_rst_start", 32'(n_starts), 32'd1);
    check("post_rst_distinct", 32'(count_seen()), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Frame loader directly upstream of the 128-point FFT sample RAM. Collects 128 audio samples from the codec-side strobe interface and writes each into the RAM write port as a complex word: real part = truncated sample, imaginary part = 0. Addresses are bit-reversed so the in-place FFT core can start on natural-order butterflies. After a full frame it pulses `fft_start`, then holds off new frames until the FFT core reports `fft_done`.

## Interface
- `N_LOG2`, 7, log2 of frame length; RAM depth = 2^N_LOG2
- `DIN_W`, 16, input sample width, two's complement
- `SMP_W`, 13, stored real/imaginary width; RAM word = 2*SMP_W
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sample_in`  in  DIN_W  signed audio sample
- `sample_valid`  in  1  one-cycle strobe; `sample_in` valid this cycle
- `fft_done`  in  1  one-cycle pulse from FFT core; frame consumed
- `ram_en`  out  1  RAM port enable; equal to `ram_we`
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  N_LOG2  RAM write address
- `ram_din`  out  2*SMP_W  {imag = 0, real = sample}; real in low SMP_W bits
- `fft_start`  out  1  one-cycle pulse; frame complete in RAM
- `busy`  out  1  high while waiting for FFT, i.e. frame owned by FFT
- `dropped`  out  8  count of samples discarded while busy; saturates at 255

## Operation
- States: FILL, WAIT_FFT. Reset state FILL with sample counter `cnt` = 0.
- In FILL, each `sample_valid`:
  - Register a write with `ram_addr` = bitrev(`cnt`) and real = `sample_in[DIN_W-1 -: SMP_W]`. Truncation drops the LSBs; there is no rounding.
  - Increment `cnt`, which wraps modulo 2^N_LOG2.
- When the write with `cnt` = 2^N_LOG2-1 is accepted, go to WAIT_FFT. `cnt` wraps to 0.
- In WAIT_FFT:
  - `sample_valid` produces no RAM write and increments `dropped` (saturating).
  - `fft_done` returns the block to FILL.
- `fft_done` received in FILL is ignored.
- `dropped` clears only on reset. It is never cleared by frame boundaries.
- Reset mid-frame:
  - The partial frame is abandoned and `cnt` returns to 0.
  - RAM contents are not cleared. The next frame overwrites every address.

## Timing
- Reset values: `ram_en`, `ram_we`, `fft_start`, `busy` = 0; `ram_addr` = 0; `ram_din` = 0; `dropped` = 0.
- All outputs are registered.
- Write latency: `sample_valid` at cycle t gives `ram_we`/`ram_en` high for exactly cycle t+1, with matching `ram_addr`/`ram_din`.
- `ram_din` and `ram_addr` hold their last values when `ram_we` = 0.
- 128th sample at cycle t:
  - Write at t+1.
  - `fft_start` high at t+2 only, so the last write is committed before the FFT reads.
  - `busy` high from t+1.
- `fft_done` at cycle u in WAIT_FFT: `busy` low from u+1. A `sample_valid` at u+1 is accepted as sample 0 of the next frame.
- Simultaneous `fft_done` and `sample_valid` in WAIT_FFT: the sample is dropped and `dropped` increments.
- Back-to-back `sample_valid` on every cycle is supported in FILL.

## Configuration
- `FFT_LOADER_BITREV_EN`
  - Defined: `ram_addr` = bit-reversed `cnt`, matching a DIT in-place FFT core.
  - Undefined: `ram_addr` = `cnt` (natural order). The FFT core performs reordering itself.
- All other behaviour is identical in both builds.

## Structure
- Shared package `fft_pkg` holds:
  - constants `FFT_N_LOG2` = 7, `FFT_SMP_W` = 13, `FFT_RAM_W` = 26;
  - the loader state enum {FILL, WAIT_FFT};
  - helper to pack {imag, real} into a RAM word.
- One natural sub-module: `bit_reverse`, purely combinational and parameterised by width. It is used for address generation under `FFT_LOADER_BITREV_EN` and reusable by the FFT output unloader.

## Test plan
- Reset, then 128 strobes with `sample_in` = 16'h0008·k: 128 writes, all addresses distinct. Sample k=1 goes to addr 64 with `ram_din` = 26'h0000001. One `fft_start` pulse two cycles after the 128th strobe.
- Sample 16'h8000 then 16'h7FFF, then 16'hFFFF: real parts 13'h1000, 13'h0FFF, 13'h1FFF; imaginary part 0 in each case.
- After a frame completes, 300 strobes with no `fft_done`: no writes, `busy` = 1, `dropped` saturates at 255. `fft_done` then clears `busy` on the next cycle and `dropped` remains 255.
- `fft_done` and `sample_valid` in the same cycle while busy: `dropped` +1. A strobe on the next cycle is written to bitrev(0) = 0.
- Assert `rst_n` low after 50 samples: all outputs 0 immediately. The next frame starts at `cnt` 0, and `fft_start` fires only after 128 further strobes.
- Build without `FFT_LOADER_BITREV_EN`: 128 strobes write addresses 0..127 in order.
